cnt_dir_decoder: RTL and testbench
==================================

Name: cnt_dir_decoder

Overview:
- Receive-side companion to up_down_cnt.
- Samples a counter value stream and recovers the direction code that produced it (dec_in0/dec_in1, same encoding as the counter's cnt_in0/cnt_in1).
- Flags wrap-around, flags illegal jumps, and reports how many consecutive samples moved the same way.
- Sits on the count_out side of the counter, for self-checking and for downstream logic that needs direction without access to the control pins.

Parameters:
- WIDTH, 4, bit width of the observed count.
- RUN_W, 8, width of run_len and err_cnt (both saturate).
- MIN_RUN, 3, consecutive identical steps required before dir_stable asserts; legal range 1..2^RUN_W-1.

Ports:
- cnt_clk  input  1  single clock, all logic on rising edge.
- cnt_rst  input  1  asynchronous, active-low reset.
- cnt_vld  input  1  cnt_val is a valid sample this cycle.
- cnt_val  input  WIDTH  observed count value.
- dec_in0  output  1  recovered down control.
- dec_in1  output  1  recovered up control.
- dir_vld  output  1  dec_in0/dec_in1 reflect a decoded step.
- dir_stable  output  1  the same direction has been seen for at least MIN_RUN consecutive steps.
- wrap_up  output  1  one-cycle pulse: max value -> 0 while counting up.
- wrap_dn  output  1  one-cycle pulse: 0 -> max value while counting down.
- err_pulse  output  1  one-cycle pulse: illegal step seen.
- run_len  output  RUN_W  consecutive steps in the current direction, saturating.
- err_cnt  output  RUN_W  total illegal steps since reset, saturating.

Behaviour:
- Reset (cnt_rst=0, asynchronous): all outputs are 0, FSM goes to SYNC, and the previous-sample register clears.
- Direction encoding {dec_in1,dec_in0}:
  - 00 = HOLD
  - 10 = UP
  - 01 = DOWN
  - 11 is never driven.
- Step arithmetic: delta = cnt_val - prev (mod 2^WIDTH). Only cycles with cnt_vld=1 are processed; cnt_vld=0 holds all state, and pulses drop to 0.
- Step classification:
  - delta=0 -> HOLD.
  - delta=1 -> UP.
  - delta=all-ones -> DOWN.
  - Any other delta -> ERR.
- Latency: every output is registered one cycle after the cnt_vld sample that produced it.
- FSM states: SYNC, HOLD, UP, DOWN, ERR.
  - SYNC: the first valid sample only loads prev. There is no decode and dir_vld stays 0. The next valid sample moves the FSM to the state given by the classification.
  - HOLD/UP/DOWN: each valid sample moves the FSM to the classified state.
  - Same state as last step: run_len increments, saturating at 2^RUN_W-1.
  - Different state: run_len = 1.
  - ERR: err_pulse=1 for one cycle and err_cnt increments (saturating). dec_in0/dec_in1 = 00, run_len = 0, dir_stable = 0.
  - Leaving ERR: the next valid sample is classified normally against the erroneous value, which has already been loaded into prev (resync in one step).
- dir_vld = 1 in HOLD/UP/DOWN, 0 in SYNC/ERR.
- dir_stable = 1 when the FSM is in UP or DOWN and run_len >= MIN_RUN. It is 0 in HOLD.
- Wrap pulses:
  - wrap_up = 1 with UP when prev = 2^WIDTH-1 and cnt_val = 0.
  - wrap_dn = 1 with DOWN when prev = 0 and cnt_val = 2^WIDTH-1.
  - A wrap is a legal step and does not reset run_len.
- prev is updated on every valid sample, including ERR samples.
- Reset asserted mid-stream: immediate return to SYNC. After release, the first sample is not decoded.

Test Plan:
1. Reset release, then cnt_val 0,1,2,3,4 with cnt_vld=1 every cycle:
   - dir_vld rises one cycle after the second sample.
   - {dec_in1,dec_in0} = 10.
   - run_len reads 1,2,3,4.
   - dir_stable rises when run_len = 3.
2. Up wrap, cnt_val 14,15,0,1:
   - wrap_up pulses exactly once, aligned with the 15->0 step.
   - run_len continues incrementing.
   - err_pulse stays 0.
3. Down wrap, cnt_val 2,1,0,15,14:
   - DOWN (01) is decoded.
   - wrap_dn pulses once, for the 0->15 step.
   - dir_stable rises after 3 down steps.
4. Hold and direction change, cnt_val 5,6,6,6,5:
   - Direction sequence: UP, HOLD, HOLD, DOWN.
   - run_len sequence: 1, 1, 2, 1.
   - dir_stable = 0 throughout.
5. Illegal jump, cnt_val 3,4,9,10:
   - The 4->9 step gives err_pulse=1 for one cycle, err_cnt = 1, dir_vld = 0.
   - The 9->10 step decodes UP with run_len = 1.
6. cnt_vld gaps and reset:
   - Samples 0,(vld=0 for 3 cycles),1: decodes UP, with outputs frozen during the gap.
   - cnt_rst low mid-run, then samples 7,8: all outputs are 0 while in reset, the first sample after release is not decoded, and 7->8 then decodes UP.

Source files
------------

// File: rtl/cnt_dir_decoder.sv
// Watches an up/down counter's output stream and recovers the direction code that drove it,
// along with wrap flags, illegal-step detection, a run length and an error count.
module cnt_dir_decoder #(
  parameter int WIDTH   = 4,
  parameter int RUN_W   = 8,
  parameter int MIN_RUN = 3
) (
  input  logic             cnt_clk,
  input  logic             cnt_rst,
  input  logic             cnt_vld,
  input  logic [WIDTH-1:0] cnt_val,
  output logic             dec_in0,
  output logic             dec_in1,
  output logic             dir_vld,
  output logic             dir_stable,
  output logic             wrap_up,
  output logic             wrap_dn,
  output logic             err_pulse,
  output logic [RUN_W-1:0] run_len,
  output logic [RUN_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    ST_SYNC = 3'd0,
    ST_HOLD = 3'd1,
    ST_UP   = 3'd2,
    ST_DOWN = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_C   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C    = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_C    = {WIDTH{1'b1}};
  localparam logic [RUN_W-1:0] RUN_MAX  = {RUN_W{1'b1}};
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_ZERO = {RUN_W{1'b0}};
  localparam logic [RUN_W-1:0] MIN_RUN_C = RUN_W'(MIN_RUN);

  state_t           state_r, state_s, class_s;
  logic [WIDTH-1:0] prev_r, prev_s, delta_s;
  logic             primed_r, primed_s;
  logic             dec_in0_r, dec_in0_s, dec_in1_r, dec_in1_s;
  logic             dir_vld_r, dir_vld_s, dir_stable_r, dir_stable_s;
  logic             wrap_up_r, wrap_up_s, wrap_dn_r, wrap_dn_s;
  logic             err_pulse_r, err_pulse_s;
  logic [RUN_W-1:0] run_len_r, run_len_s, err_cnt_r, err_cnt_s;

  // Classify the step between the previous sample and the current one (modular difference).
  always_comb begin
    delta_s = cnt_val - prev_r;
    if (delta_s == ZERO_C) begin
      class_s = ST_HOLD;
    end else if (delta_s == ONE_C) begin
      class_s = ST_UP;
    end else if (delta_s == ALL_C) begin
      class_s = ST_DOWN;
    end else begin
      class_s = ST_ERR;
    end
  end

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    state_s      = state_r;
    prev_s       = prev_r;
    primed_s     = primed_r;
    dec_in0_s    = dec_in0_r;
    dec_in1_s    = dec_in1_r;
    dir_vld_s    = dir_vld_r;
    dir_stable_s = dir_stable_r;
    wrap_up_s    = 1'b0;
    wrap_dn_s    = 1'b0;
    err_pulse_s  = 1'b0;
    run_len_s    = run_len_r;
    err_cnt_s    = err_cnt_r;
    if (cnt_vld) begin
      prev_s   = cnt_val;
      primed_s = 1'b1;
      if (primed_r) begin
        state_s = class_s;
        case (class_s)
          ST_ERR: begin
            err_pulse_s  = 1'b1;
            err_cnt_s    = (err_cnt_r == RUN_MAX) ? RUN_MAX : err_cnt_r + RUN_ONE;
            run_len_s    = RUN_ZERO;
            dec_in0_s    = 1'b0;
            dec_in1_s    = 1'b0;
            dir_vld_s    = 1'b0;
            dir_stable_s = 1'b0;
          end
          default: begin
            // Coming from SYNC or ERR never matches class_s, so the run restarts at one.
            if (class_s == state_r) begin
              run_len_s = (run_len_r == RUN_MAX) ? RUN_MAX : run_len_r + RUN_ONE;
            end else begin
              run_len_s = RUN_ONE;
            end
            dir_vld_s    = 1'b1;
            dec_in1_s    = (class_s == ST_UP);
            dec_in0_s    = (class_s == ST_DOWN);
            dir_stable_s = (class_s != ST_HOLD) && (run_len_s >= MIN_RUN_C);
            wrap_up_s    = (class_s == ST_UP) && (prev_r == ALL_C) && (cnt_val == ZERO_C);
            wrap_dn_s    = (class_s == ST_DOWN) && (prev_r == ZERO_C) && (cnt_val == ALL_C);
          end
        endcase
      end else begin
        state_s = ST_SYNC;
      end
    end else begin
      state_s = state_r;
    end
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge cnt_clk or negedge cnt_rst) begin
    if (!cnt_rst) begin
      state_r      <= ST_SYNC;
      prev_r       <= ZERO_C;
      primed_r     <= 1'b0;
      dec_in0_r    <= 1'b0;
      dec_in1_r    <= 1'b0;
      dir_vld_r    <= 1'b0;
      dir_stable_r <= 1'b0;
      wrap_up_r    <= 1'b0;
      wrap_dn_r    <= 1'b0;
      err_pulse_r  <= 1'b0;
      run_len_r    <= RUN_ZERO;
      err_cnt_r    <= RUN_ZERO;
    end else begin
      state_r      <= state_s;
      prev_r       <= prev_s;
      primed_r     <= primed_s;
      dec_in0_r    <= dec_in0_s;
      dec_in1_r    <= dec_in1_s;
      dir_vld_r    <= dir_vld_s;
      dir_stable_r <= dir_stable_s;
      wrap_up_r    <= wrap_up_s;
      wrap_dn_r    <= wrap_dn_s;
      err_pulse_r  <= err_pulse_s;
      run_len_r    <= run_len_s;
      err_cnt_r    <= err_cnt_s;
    end
  end

  assign dec_in0    = dec_in0_r;
  assign dec_in1    = dec_in1_r;
  assign dir_vld    = dir_vld_r;
  assign dir_stable = dir_stable_r;
  assign wrap_up    = wrap_up_r;
  assign wrap_dn    = wrap_dn_r;
  assign err_pulse  = err_pulse_r;
  assign run_len    = run_len_r;
  assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_cnt_dir_decoder.sv
// Directed bench for cnt_dir_decoder: hand-computed flag/run/error expectations per sample.
module tb_cnt_dir_decoder;

  logic       cnt_clk = 1'b0;
  logic       cnt_rst = 1'b0;
  logic       cnt_vld = 1'b0;
  logic [3:0] cnt_val = 4'd0;
  logic       dec_in0, dec_in1, dir_vld, dir_stable, wrap_up, wrap_dn, err_pulse;
  logic [7:0] run_len, err_cnt;

  int checks_r = 0;
  int passed_r = 0;

  cnt_dir_decoder #(.WIDTH(4), .RUN_W(8), .MIN_RUN(3)) dut (
    .cnt_clk(cnt_clk), .cnt_rst(cnt_rst), .cnt_vld(cnt_vld), .cnt_val(cnt_val),
    .dec_in0(dec_in0), .dec_in1(dec_in1), .dir_vld(dir_vld), .dir_stable(dir_stable),
    .wrap_up(wrap_up), .wrap_dn(wrap_dn), .err_pulse(err_pulse),
    .run_len(run_len), .err_cnt(err_cnt)
  );

  always #5 cnt_clk = ~cnt_clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks_r++;
    if (obs === exp) passed_r++;
    else $display("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  // flags = {dir_vld, dec_in1, dec_in0, dir_stable, wrap_up, wrap_dn, err_pulse}
  task automatic check_all(input string tag, input logic [6:0] flags, input logic [7:0] run,
                           input logic [7:0] err);
    check({tag, ".flags"}, {9'd0, dir_vld, dec_in1, dec_in0, dir_stable, wrap_up, wrap_dn, err_pulse},
          {9'd0, flags});
    check({tag, ".run"}, {8'd0, run_len}, {8'd0, run});
    check({tag, ".err"}, {8'd0, err_cnt}, {8'd0, err});
  endtask

  task automatic sample(input logic [3:0] v);
    cnt_vld = 1'b1;
    cnt_val = v;
    @(posedge cnt_clk);
    #1;
  endtask

  task automatic idle();
    cnt_vld = 1'b0;
    @(posedge cnt_clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    cnt_vld = 1'b0;
    cnt_rst = 1'b0;
    #2;
    check_all({tag, ".rst"}, 7'b0000000, 8'd0, 8'd0);
    @(posedge cnt_clk);
    #1;
    cnt_rst = 1'b1;
  endtask

  initial begin
    #3;
    do_reset("t0");

    // Count up from zero
    sample(4'd0); check_all("t1.s0", 7'b0000000, 8'd0, 8'd0);
    sample(4'd1); check_all("t1.s1", 7'b1100000, 8'd1, 8'd0);
    sample(4'd2); check_all("t1.s2", 7'b1100000, 8'd2, 8'd0);
    sample(4'd3); check_all("t1.s3", 7'b1101000, 8'd3, 8'd0);
    sample(4'd4); check_all("t1.s4", 7'b1101000, 8'd4, 8'd0);

    // Up wrap
    do_reset("t2");
    sample(4'd14); check_all("t2.s14", 7'b0000000, 8'd0, 8'd0);
    sample(4'd15); check_all("t2.s15", 7'b1100000, 8'd1, 8'd0);
    sample(4'd0);  check_all("t2.s0",  7'b1100100, 8'd2, 8'd0);
    sample(4'd1);  check_all("t2.s1",  7'b1101000, 8'd3, 8'd0);

    // Down wrap
    do_reset("t3");
    sample(4'd2);  check_all("t3.s2",  7'b0000000, 8'd0, 8'd0);
    sample(4'd1);  check_all("t3.s1",  7'b1010000, 8'd1, 8'd0);
    sample(4'd0);  check_all("t3.s0",  7'b1010000, 8'd2, 8'd0);
    sample(4'd15); check_all("t3.s15", 7'b1011010, 8'd3, 8'd0);
    sample(4'd14); check_all("t3.s14", 7'b1011000, 8'd4, 8'd0);

    // Hold and direction change
    do_reset("t4");
    sample(4'd5); check_all("t4.a", 7'b0000000, 8'd0, 8'd0);
    sample(4'd6); check_all("t4.b", 7'b1100000, 8'd1, 8'd0);
    sample(4'd6); check_all("t4.c", 7'b1000000, 8'd1, 8'd0);
    sample(4'd6); check_all("t4.d", 7'b1000000, 8'd2, 8'd0);
    sample(4'd5); check_all("t4.e", 7'b1010000, 8'd1, 8'd0);

    // Illegal jump and one-step resync
    do_reset("t5");
    sample(4'd3);  check_all("t5.s3",  7'b0000000, 8'd0, 8'd0);
    sample(4'd4);  check_all("t5.s4",  7'b1100000, 8'd1, 8'd0);
    sample(4'd9);  check_all("t5.s9",  7'b0000001, 8'd0, 8'd1);
    sample(4'd10); check_all("t5.s10", 7'b1100000, 8'd1, 8'd1);
    idle();        check_all("t5.gap", 7'b1100000, 8'd1, 8'd1);

    // Valid gaps freeze state
    do_reset("t6");
    sample(4'd0); check_all("t6.s0", 7'b0000000, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      idle(); check_all("t6.gap0", 7'b0000000, 8'd0, 8'd0);
    end
    sample(4'd1); check_all("t6.s1", 7'b1100000, 8'd1, 8'd0);
    for (int i = 0; i < 2; i++) begin
      idle(); check_all("t6.gap1", 7'b1100000, 8'd1, 8'd0);
    end
    sample(4'd2); check_all("t6.s2", 7'b1100000, 8'd2, 8'd0);

    // Mid-run reset, first sample after release is not decoded
    do_reset("t6m");
    sample(4'd7); check_all("t6.s7", 7'b0000000, 8'd0, 8'd0);
    sample(4'd8); check_all("t6.s8", 7'b1100000, 8'd1, 8'd0);

    $display("%0d/%0d checks passed", passed_r, checks_r);
    $finish;
  end

endmodule
